// File: rtl/popcnt_frame_acc.sv
// Frame accumulator: sums per-word popcounts over a valid/ready frame and reports total, beat count and overflow.
// Optional build macro POPCNT_ACC_SAT_EN selects saturating (defined) or wrapping (undefined) accumulation.
module popcnt_frame_acc #(
  parameter int DATA_W    = 10,
  parameter int POS_W     = $clog2(DATA_W+1),
  parameter int MAX_WORDS = 16,
  localparam int ACC_W    = $clog2(DATA_W*MAX_WORDS+1),
  localparam int CNT_W    = $clog2(MAX_WORDS+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [POS_W-1:0] in_sum,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [CNT_W-1:0] out_words,
  output logic             out_ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state_p0;
  logic [ACC_W-1:0] acc_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic             ovf_p0;
  logic [ACC_W:0]   acc_nxt;
  logic             take;
  logic             cnt_full;

  // Returns {limit_hit, sum}; limit_hit only ever rises in the saturating build.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                             input logic [POS_W-1:0] s);
    logic [ACC_W:0] sum;
    sum = {1'b0, a} + (ACC_W+1)'(s);
`ifdef POPCNT_ACC_SAT_EN
    if (sum[ACC_W])
      return {1'b1, {ACC_W{1'b1}}};
    return {1'b0, sum[ACC_W-1:0]};
`else
    return {1'b0, sum[ACC_W-1:0]};
`endif
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
`ifdef POPCNT_ACC_SAT_EN
    if (c == CNT_W'(MAX_WORDS))
      return c;
    return c + CNT_W'(1);
`else
    return c + CNT_W'(1);
`endif
  endfunction

  assign take      = in_valid && in_ready;
  assign cnt_full  = (cnt_p0 == CNT_W'(MAX_WORDS));
  assign acc_nxt   = acc_add(acc_p0, in_sum);

  assign out_total = acc_p0;
  assign out_words = cnt_p0;
  assign out_ovf   = ovf_p0;

  // Control and result registers; handshake flags are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0  <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      acc_p0    <= '0;
      cnt_p0    <= '0;
      ovf_p0    <= 1'b0;
    end else begin
      case (state_p0)
        IDLE: begin
          if (take) begin
            acc_p0 <= ACC_W'(in_sum);
            cnt_p0 <= CNT_W'(1);
            ovf_p0 <= 1'b0;
            if (in_last) begin
              state_p0  <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state_p0 <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (take) begin
            acc_p0 <= acc_nxt[ACC_W-1:0];
            cnt_p0 <= cnt_inc(cnt_p0);
            if (cnt_full || acc_nxt[ACC_W])
              ovf_p0 <= 1'b1;
            if (in_last) begin
              state_p0  <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_p0  <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state_p0  <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_popcnt_frame_acc.sv
// Directed bench for popcnt_frame_acc at default parameters (ACC_W=8, CNT_W=5).
// Expected values follow the POPCNT_ACC_SAT_EN setting of the build.
module tb_popcnt_frame_acc;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_sum;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_total;
  logic [4:0] out_words;
  logic       out_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  popcnt_frame_acc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_total (out_total),
    .out_words (out_words),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [3:0] s, input logic l);
    in_valid = 1'b1;
    in_sum   = s;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_last = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_total", out_total, 0);
    chk("rst_words", out_words, 0);
    chk("rst_ovf", out_ovf, 0);

    // single-beat frame with out_ready already high
    out_ready = 1'b1;
    beat(4'd7, 1'b1);
    chk("single_valid", out_valid, 1);
    chk("single_total", out_total, 7);
    chk("single_words", out_words, 1);
    chk("single_ovf", out_ovf, 0);
    chk("single_in_ready", in_ready, 0);
    tick();
    chk("single_idle_valid", out_valid, 0);
    chk("single_idle_ready", in_ready, 1);
    out_ready = 1'b0;

    // four beats with gaps
    beat(4'd10, 1'b0);
    tick();
    beat(4'd0, 1'b0);
    tick();
    tick();
    beat(4'd3, 1'b0);
    chk("gap_mid_valid", out_valid, 0);
    tick();
    beat(4'd5, 1'b1);
    chk("gap_valid", out_valid, 1);
    chk("gap_total", out_total, 18);
    chk("gap_words", out_words, 4);
    chk("gap_ovf", out_ovf, 0);

    // backpressure: result held, extra beats refused
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_sum = 4'd9; in_last = 1'b1;
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_total", out_total, 18);
      chk("bp_words", out_words, 4);
    end
    in_valid = 1'b0; in_last = 1'b0;
    drain();
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    chk("bp_release_total", out_total, 18);

    // 17 beats of 10: count overflow
    for (int i = 1; i <= 17; i++) begin
      beat(4'd10, (i == 17));
      if (i == 16) chk("ovf16_ovf", out_ovf, 0);
    end
    chk("ovf17_valid", out_valid, 1);
    chk("ovf17_ovf", out_ovf, 1);
    chk("ovf17_total", out_total, 170);
`ifdef POPCNT_ACC_SAT_EN
    chk("ovf17_words", out_words, 16);
`else
    chk("ovf17_words", out_words, 17);
`endif
    drain();

    // 18 beats of 15: accumulator limit
    for (int i = 1; i <= 18; i++) beat(4'd15, (i == 18));
    chk("sat18_valid", out_valid, 1);
    chk("sat18_ovf", out_ovf, 1);
`ifdef POPCNT_ACC_SAT_EN
    chk("sat18_total", out_total, 255);
    chk("sat18_words", out_words, 16);
`else
    chk("sat18_total", out_total, 14);
    chk("sat18_words", out_words, 18);
`endif
    drain();

    // next frame clears the sticky overflow
    beat(4'd1, 1'b1);
    chk("clr_ovf", out_ovf, 0);
    chk("clr_total", out_total, 1);
    chk("clr_words", out_words, 1);
    drain();

    // reset mid-frame, with a beat presented during reset
    beat(4'd4, 1'b0);
    beat(4'd4, 1'b0);
    beat(4'd4, 1'b0);
    chk("mid_total", out_total, 12);
    chk("mid_words", out_words, 3);
    rst = 1'b1; in_valid = 1'b1; in_sum = 4'd5; in_last = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ready", in_ready, 1);
    chk("midrst_total", out_total, 0);
    chk("midrst_words", out_words, 0);
    chk("midrst_ovf", out_ovf, 0);
    tick();
    tick();
    chk("midrst_no_stale", out_valid, 0);
    beat(4'd2, 1'b1);
    chk("post_valid", out_valid, 1);
    chk("post_total", out_total, 2);
    chk("post_words", out_words, 1);
    chk("post_ovf", out_ovf, 0);

    // reset while a result is pending
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("donerst_valid", out_valid, 0);
    chk("donerst_ready", in_ready, 1);
    chk("donerst_total", out_total, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/popcnt_frame_acc.md
POPCNT_FRAME_ACC -- requirements
Module: popcnt_frame_acc

Interface
REQ-001 SHALL have parameter DATA_W, default 10, width of the data words whose popcounts arrive upstream.
REQ-002 SHALL have parameter POS_W, default $clog2(DATA_W+1), width of one per-word popcount.
REQ-003 SHALL have parameter MAX_WORDS, default 16, maximum legal words per frame.
REQ-004 SHALL have derived parameters ACC_W = $clog2(DATA_W*MAX_WORDS+1) and CNT_W = $clog2(MAX_WORDS+1).
REQ-005 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1, upstream beat valid.
REQ-008 SHALL have port in_ready, output, 1, block accepts a beat.
REQ-009 SHALL have port in_sum, input, POS_W, per-word popcount.
REQ-010 SHALL have port in_last, input, 1, beat is the last of its frame.
REQ-011 SHALL have port out_valid, output, 1, frame result available.
REQ-012 SHALL have port out_ready, input, 1, downstream takes the result.
REQ-013 SHALL have port out_total, output, ACC_W, sum of in_sum over the frame.
REQ-014 SHALL have port out_words, output, CNT_W, number of beats in the frame.
REQ-015 SHALL have port out_ovf, output, 1, frame exceeded MAX_WORDS beats or the accumulator overflowed.

Function
REQ-016 SHALL accept a beat only when in_valid and in_ready are both 1 in the same cycle.
REQ-017 SHALL implement the states IDLE, ACCUM and DONE.
REQ-018 SHALL, in IDLE, drive in_ready=1 and out_valid=0.
REQ-019 SHALL, on acceptance in IDLE, load the accumulator with in_sum and the count with 1, then go to DONE if in_last=1, otherwise to ACCUM.
REQ-020 SHALL, in ACCUM, drive in_ready=1 and add in_sum to the accumulator and 1 to the count on each accepted beat; a beat with in_last=1 moves the block to DONE.
REQ-021 SHALL, in DONE, drive in_ready=0 and out_valid=1, and hold out_total, out_words and out_ovf stable until out_ready=1.
REQ-022 SHALL go from DONE to IDLE in the cycle in which out_ready=1; the next beat is accepted no earlier than the following cycle.
REQ-023 SHALL assert out_valid exactly one cycle after the beat carrying in_last is accepted.
REQ-024 SHALL set out_ovf sticky for the frame when a beat is accepted while the count already equals MAX_WORDS, and SHALL clear it when the next frame's first beat is accepted.
REQ-025 SHALL add in_sum zero-extended to ACC_W; values of in_sum above DATA_W are a caller error and SHALL be added unmodified.
REQ-026 SHALL ignore in_sum and in_last whenever in_valid=0.
REQ-027 SHALL have out_total, out_words and out_ovf reflect the internal registers in all states; they are meaningful only while out_valid=1.

Reset
REQ-028 SHALL, while rst=1 at a clock edge, enter IDLE and clear the accumulator, count and out_ovf, giving out_valid=0, in_ready=1, out_total=0, out_words=0 and out_ovf=0 after that edge.
REQ-029 SHALL, when reset occurs mid-frame or in DONE, discard the partial or pending result with no output beat.
REQ-030 SHALL ignore in_valid and out_ready in any cycle in which rst=1.

Configuration
REQ-031 SHALL use the macro POPCNT_ACC_SAT_EN.
REQ-032 SHALL, with POPCNT_ACC_SAT_EN defined, saturate the accumulator at 2**ACC_W-1 and the count at MAX_WORDS, and set out_ovf if either would exceed its limit.
REQ-033 SHALL, with POPCNT_ACC_SAT_EN undefined, wrap the accumulator modulo 2**ACC_W and the count modulo 2**CNT_W, and set out_ovf only by the rule in REQ-024.

Verification
Defaults are DATA_W=10, MAX_WORDS=16, ACC_W=8, CNT_W=5.
REQ-034 SHALL cover a single-beat frame: in_sum=7 with in_last=1 and out_ready=1 -> next cycle out_valid=1, out_total=7, out_words=1, out_ovf=0, then IDLE one cycle later.
REQ-035 SHALL cover a four-beat frame with gaps: sums 10, 0, 3, 5, in_valid low between beats -> out_total=18, out_words=4, out_ovf=0.
REQ-036 SHALL cover backpressure: frame done while out_ready=0 for 5 cycles -> out_valid and outputs held, in_ready=0, extra in_valid beats not accepted.
REQ-037 SHALL cover overflow: 17 beats of in_sum=10, last on the 17th -> out_ovf=1; with POPCNT_ACC_SAT_EN out_total=170 (fits), out_words=16; without it out_words=17.
REQ-038 SHALL cover accumulator saturation with a forced in_sum=15 over 18 beats -> with POPCNT_ACC_SAT_EN out_total=255 and out_ovf=1; without it out_total=270 mod 256=14 and out_ovf=1 (from the count).
REQ-039 SHALL cover reset mid-frame: rst asserted after 3 beats, then a frame of in_sum=2 with in_last -> out_total=2, out_words=1, with no stale result emitted.
